mem_issue_queue: RTL and testbench

- In-order load/store issue queue sitting directly upstream of the memory functional unit.
- Buffers dispatched memory ops and captures source operands from dispatch or CDB wakeup.
- Issues the oldest op as a one-cycle start pulse with full operand values when the memory unit is idle.
- Strict program order, so loads never pass stores; address calculation and store commit stay in the memory unit.

---
 rtl/mem_issue_queue.sv | 197 +++++++++++++++++++
 tb/tb_mem_issue_queue.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_issue_queue.sv
// In-order load/store issue queue feeding the memory unit.
// Optional: MEMQ_PERF_CNT_EN adds full/wait cycle counters.
module mem_issue_queue #(
    parameter int DEPTH     = 8,
    parameter int PHYS_W    = 6,
    parameter int ROB_W     = 5,
    parameter int PAYLOAD_W = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       dispatch_valid,
    output logic                       dispatch_ready,
    input  logic [ROB_W-1:0]           dispatch_rob,
    input  logic [PHYS_W-1:0]          dispatch_rs1_ps,
    input  logic                       dispatch_rs1_rdy,
    input  logic [31:0]                dispatch_rs1_v,
    input  logic [PHYS_W-1:0]          dispatch_rs2_ps,
    input  logic                       dispatch_rs2_rdy,
    input  logic [31:0]                dispatch_rs2_v,
    input  logic [PAYLOAD_W-1:0]       dispatch_payload,
    input  logic                       cdb_valid,
    input  logic [PHYS_W-1:0]          cdb_phys_rd,
    input  logic [31:0]                cdb_data,
    input  logic                       mem_in_use,
    input  logic                       stall,
    output logic                       issue_start,
    output logic [ROB_W-1:0]           issue_rob,
    output logic [31:0]                issue_rs1_v,
    output logic [31:0]                issue_rs2_v,
    output logic [PAYLOAD_W-1:0]       issue_payload,
`ifdef MEMQ_PERF_CNT_EN
    output logic [31:0]                perf_full_cycles,
    output logic [31:0]                perf_wait_cycles,
`endif
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic                 e_valid   [DEPTH];
    logic [ROB_W-1:0]     e_rob     [DEPTH];
    logic [PHYS_W-1:0]    e_rs1_ps  [DEPTH];
    logic                 e_rs1_rdy [DEPTH];
    logic [31:0]          e_rs1_v   [DEPTH];
    logic [PHYS_W-1:0]    e_rs2_ps  [DEPTH];
    logic                 e_rs2_rdy [DEPTH];
    logic [31:0]          e_rs2_v   [DEPTH];
    logic [PAYLOAD_W-1:0] e_payload [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             issued_q;

    logic             full;
    logic             do_disp;
    logic             can_issue;
    logic             d_rs1_rdy;
    logic             d_rs2_rdy;
    logic [31:0]      d_rs1_v;
    logic [31:0]      d_rs2_v;

    assign full           = (count == CNT_W'(DEPTH));
    assign dispatch_ready = !full;

    // Accept, issue decision and dispatch-time operand resolution
    always_comb begin
        do_disp   = dispatch_valid && dispatch_ready && !flush;
        can_issue = e_valid[head] && e_rs1_rdy[head] && e_rs2_rdy[head]
                    && !mem_in_use && !stall && !issued_q && !flush;
        d_rs1_rdy = 1'b1;
        d_rs1_v   = 32'd0;
        if (dispatch_rs1_ps != '0) begin
            if (dispatch_rs1_rdy) begin
                d_rs1_v = dispatch_rs1_v;
            end else if (cdb_valid && cdb_phys_rd == dispatch_rs1_ps) begin
                d_rs1_v = cdb_data;
            end else begin
                d_rs1_rdy = 1'b0;
            end
        end
        d_rs2_rdy = 1'b1;
        d_rs2_v   = 32'd0;
        if (dispatch_rs2_ps != '0) begin
            if (dispatch_rs2_rdy) begin
                d_rs2_v = dispatch_rs2_v;
            end else if (cdb_valid && cdb_phys_rd == dispatch_rs2_ps) begin
                d_rs2_v = cdb_data;
            end else begin
                d_rs2_rdy = 1'b0;
            end
        end
    end

    // Entry storage: wakeup, dispatch write and free on issue
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                e_valid[i]   <= 1'b0;
                e_rob[i]     <= '0;
                e_rs1_ps[i]  <= '0;
                e_rs1_rdy[i] <= 1'b0;
                e_rs1_v[i]   <= '0;
                e_rs2_ps[i]  <= '0;
                e_rs2_rdy[i] <= 1'b0;
                e_rs2_v[i]   <= '0;
                e_payload[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                e_valid[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (e_valid[i] && cdb_valid) begin
                    if (!e_rs1_rdy[i] && e_rs1_ps[i] == cdb_phys_rd) begin
                        e_rs1_rdy[i] <= 1'b1;
                        e_rs1_v[i]   <= cdb_data;
                    end
                    if (!e_rs2_rdy[i] && e_rs2_ps[i] == cdb_phys_rd) begin
                        e_rs2_rdy[i] <= 1'b1;
                        e_rs2_v[i]   <= cdb_data;
                    end
                end
            end
            if (can_issue) begin
                e_valid[head] <= 1'b0;
            end
            if (do_disp) begin
                e_valid[tail]   <= 1'b1;
                e_rob[tail]     <= dispatch_rob;
                e_rs1_ps[tail]  <= dispatch_rs1_ps;
                e_rs1_rdy[tail] <= d_rs1_rdy;
                e_rs1_v[tail]   <= d_rs1_v;
                e_rs2_ps[tail]  <= dispatch_rs2_ps;
                e_rs2_rdy[tail] <= d_rs2_rdy;
                e_rs2_v[tail]   <= d_rs2_v;
                e_payload[tail] <= dispatch_payload;
            end
        end
    end

    // Pointers, occupancy and the registered issue port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            issued_q      <= 1'b0;
            issue_start   <= 1'b0;
            issue_rob     <= '0;
            issue_rs1_v   <= '0;
            issue_rs2_v   <= '0;
            issue_payload <= '0;
        end else if (flush) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            issued_q    <= 1'b0;
            issue_start <= 1'b0;
        end else begin
            issued_q    <= can_issue;
            issue_start <= can_issue;
            if (can_issue) begin
                issue_rob     <= e_rob[head];
                issue_rs1_v   <= e_rs1_v[head];
                issue_rs2_v   <= e_rs2_v[head];
                issue_payload <= e_payload[head];
                head          <= head + PTR_W'(1);
            end
            if (do_disp) begin
                tail <= tail + PTR_W'(1);
            end
            count <= count + CNT_W'(do_disp) - CNT_W'(can_issue);
        end
    end

`ifdef MEMQ_PERF_CNT_EN
    // Saturating stall counters; flush leaves them alone
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_full_cycles <= '0;
            perf_wait_cycles <= '0;
        end else begin
            if (full && dispatch_valid && perf_full_cycles != '1) begin
                perf_full_cycles <= perf_full_cycles + 32'd1;
            end
            if (e_valid[head] && !(e_rs1_rdy[head] && e_rs2_rdy[head])
                && perf_wait_cycles != '1) begin
                perf_wait_cycles <= perf_wait_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_issue_queue.sv
// Directed testbench for mem_issue_queue.
// Each task drives one scenario and checks inline.
module tb_mem_issue_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        dispatch_valid;
    logic        dispatch_ready;
    logic [4:0]  dispatch_rob;
    logic [5:0]  dispatch_rs1_ps;
    logic        dispatch_rs1_rdy;
    logic [31:0] dispatch_rs1_v;
    logic [5:0]  dispatch_rs2_ps;
    logic        dispatch_rs2_rdy;
    logic [31:0] dispatch_rs2_v;
    logic [63:0] dispatch_payload;
    logic        cdb_valid;
    logic [5:0]  cdb_phys_rd;
    logic [31:0] cdb_data;
    logic        mem_in_use;
    logic        stall;
    logic        issue_start;
    logic [4:0]  issue_rob;
    logic [31:0] issue_rs1_v;
    logic [31:0] issue_rs2_v;
    logic [63:0] issue_payload;
`ifdef MEMQ_PERF_CNT_EN
    logic [31:0] perf_full_cycles;
    logic [31:0] perf_wait_cycles;
`endif
    logic [3:0]  count;

    int errs = 0;
    int checks = 0;

    mem_issue_queue dut (
        .clk(clk), .rst(rst), .flush(flush),
        .dispatch_valid(dispatch_valid),
        .dispatch_ready(dispatch_ready),
        .dispatch_rob(dispatch_rob),
        .dispatch_rs1_ps(dispatch_rs1_ps),
        .dispatch_rs1_rdy(dispatch_rs1_rdy),
        .dispatch_rs1_v(dispatch_rs1_v),
        .dispatch_rs2_ps(dispatch_rs2_ps),
        .dispatch_rs2_rdy(dispatch_rs2_rdy),
        .dispatch_rs2_v(dispatch_rs2_v),
        .dispatch_payload(dispatch_payload),
        .cdb_valid(cdb_valid),
        .cdb_phys_rd(cdb_phys_rd),
        .cdb_data(cdb_data),
        .mem_in_use(mem_in_use),
        .stall(stall),
        .issue_start(issue_start),
        .issue_rob(issue_rob),
        .issue_rs1_v(issue_rs1_v),
        .issue_rs2_v(issue_rs2_v),
        .issue_payload(issue_payload),
`ifdef MEMQ_PERF_CNT_EN
        .perf_full_cycles(perf_full_cycles),
        .perf_wait_cycles(perf_wait_cycles),
`endif
        .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] pl(input logic [4:0] rob);
        return {32'hC0DE_0000, 27'd0, rob};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input logic [4:0] rob,
                        input logic [5:0] p1, input logic r1,
                        input logic [31:0] v1,
                        input logic [5:0] p2, input logic r2,
                        input logic [31:0] v2);
        dispatch_valid   = 1'b1;
        dispatch_rob     = rob;
        dispatch_rs1_ps  = p1;
        dispatch_rs1_rdy = r1;
        dispatch_rs1_v   = v1;
        dispatch_rs2_ps  = p2;
        dispatch_rs2_rdy = r2;
        dispatch_rs2_v   = v2;
        dispatch_payload = pl(rob);
    endtask

    task automatic push(input logic [4:0] rob,
                        input logic [5:0] p1, input logic r1,
                        input logic [31:0] v1,
                        input logic [5:0] p2, input logic r2,
                        input logic [31:0] v2);
        disp(rob, p1, r1, v1, p2, r2, v2);
        tick();
        dispatch_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; dispatch_valid = 1'b0;
        disp(5'd0, 6'd0, 1'b0, 32'd0, 6'd0, 1'b0, 32'd0);
        dispatch_valid = 1'b0;
        cdb_valid = 1'b0; cdb_phys_rd = '0; cdb_data = '0;
        mem_in_use = 1'b0; stall = 1'b0;
        tick(); tick();
        checks++;
        if (count !== 4'd0) begin
            errs++; $display("FAIL reset_count got=%0d exp=0", count);
        end
        checks++;
        if (issue_start !== 1'b0 || dispatch_ready !== 1'b1) begin
            errs++;
            $display("FAIL reset_ctl start=%b ready=%b exp 0/1",
                     issue_start, dispatch_ready);
        end
        checks++;
        if (issue_rob !== 5'd0 || issue_rs1_v !== 32'd0
            || issue_payload !== 64'd0) begin
            errs++;
            $display("FAIL reset_data rob=%0d rs1=%h exp zeros",
                     issue_rob, issue_rs1_v);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        push(5'd3, 6'd5, 1'b1, 32'h1000, 6'd0, 1'b0, 32'hFFFF);
        checks++;
        if (issue_start !== 1'b0 || count !== 4'd1) begin
            errs++;
            $display("FAIL basic_queued start=%b count=%0d exp 0/1",
                     issue_start, count);
        end
        tick();
        checks++;
        if (issue_start !== 1'b1 || issue_rob !== 5'd3
            || issue_rs1_v !== 32'h1000 || issue_rs2_v !== 32'd0
            || issue_payload !== pl(5'd3) || count !== 4'd0) begin
            errs++;
            $display("FAIL basic_issue start=%b rob=%0d rs1=%h rs2=%h cnt=%0d exp 1/3/1000/0/0",
                     issue_start, issue_rob, issue_rs1_v, issue_rs2_v, count);
        end
        tick();
        checks++;
        if (issue_start !== 1'b0 || issue_rob !== 5'd3) begin
            errs++;
            $display("FAIL basic_hold start=%b rob=%0d exp 0/3",
                     issue_start, issue_rob);
        end
        tick();
    endtask

    task automatic test_wakeup();
        logic early;
        early = 1'b0;
        push(5'd4, 6'd2, 1'b1, 32'h2000, 6'd9, 1'b0, 32'h1111);
        cdb_valid = 1'b1; cdb_phys_rd = 6'd2; cdb_data = 32'hBAD;
        tick();
        early |= issue_start;
        cdb_valid = 1'b0;
        tick(); early |= issue_start;
        tick(); early |= issue_start;
        cdb_valid = 1'b1; cdb_phys_rd = 6'd9; cdb_data = 32'hDEADBEEF;
        tick(); early |= issue_start;
        cdb_valid = 1'b0;
        checks++;
        if (early !== 1'b0) begin
            errs++; $display("FAIL wake_early got=%b exp=0", early);
        end
        tick();
        checks++;
        if (issue_start !== 1'b1 || issue_rob !== 5'd4
            || issue_rs2_v !== 32'hDEADBEEF) begin
            errs++;
            $display("FAIL wake_issue start=%b rob=%0d rs2=%h exp 1/4/deadbeef",
                     issue_start, issue_rob, issue_rs2_v);
        end
        checks++;
        if (issue_rs1_v !== 32'h2000) begin
            errs++;
            $display("FAIL wake_no_overwrite got=%h exp=2000", issue_rs1_v);
        end
        tick(); tick();
    endtask

    task automatic test_same_cycle_wake();
        disp(5'd5, 6'd7, 1'b0, 32'h999, 6'd0, 1'b1, 32'h0);
        cdb_valid = 1'b1; cdb_phys_rd = 6'd7; cdb_data = 32'h55;
        tick();
        dispatch_valid = 1'b0; cdb_valid = 1'b0;
        tick();
        checks++;
        if (issue_start !== 1'b1 || issue_rob !== 5'd5
            || issue_rs1_v !== 32'h55) begin
            errs++;
            $display("FAIL same_wake start=%b rob=%0d rs1=%h exp 1/5/55",
                     issue_start, issue_rob, issue_rs1_v);
        end
        tick(); tick();
    endtask

    task automatic test_disp_issue_same();
        push(5'd1, 6'd3, 1'b1, 32'h31, 6'd0, 1'b0, 32'h0);
        disp(5'd2, 6'd4, 1'b1, 32'h42, 6'd0, 1'b0, 32'h0);
        tick();
        dispatch_valid = 1'b0;
        checks++;
        if (issue_start !== 1'b1 || issue_rob !== 5'd1 || count !== 4'd1) begin
            errs++;
            $display("FAIL overlap start=%b rob=%0d cnt=%0d exp 1/1/1",
                     issue_start, issue_rob, count);
        end
        tick();
        checks++;
        if (issue_start !== 1'b0) begin
            errs++; $display("FAIL overlap_gap got=%b exp=0", issue_start);
        end
        tick();
        checks++;
        if (issue_start !== 1'b1 || issue_rob !== 5'd2
            || issue_rs1_v !== 32'h42 || count !== 4'd0) begin
            errs++;
            $display("FAIL overlap_second start=%b rob=%0d cnt=%0d exp 1/2/0",
                     issue_start, issue_rob, count);
        end
        tick(); tick();
    endtask

    task automatic test_full();
        int got;
        logic prev;
        mem_in_use = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push(5'(10 + i), 6'(1 + i), 1'b1, 32'hA000 + 32'(i),
                 6'd0, 1'b1, 32'h0);
        end
        checks++;
        if (count !== 4'd8 || dispatch_ready !== 1'b0) begin
            errs++;
            $display("FAIL full_state cnt=%0d ready=%b exp 8/0",
                     count, dispatch_ready);
        end
        push(5'd31, 6'd1, 1'b1, 32'h1, 6'd0, 1'b1, 32'h0);
        checks++;
        if (count !== 4'd8) begin
            errs++; $display("FAIL full_drop cnt=%0d exp=8", count);
        end
        mem_in_use = 1'b0;
        got = 0;
        prev = 1'b0;
        for (int c = 0; c < 40 && got < 8; c++) begin
            tick();
            if (issue_start) begin
                checks++;
                if (issue_rob !== 5'(10 + got)
                    || issue_rs1_v !== 32'hA000 + 32'(got) || prev) begin
                    errs++;
                    $display("FAIL full_order rob=%0d rs1=%h b2b=%b exp %0d",
                             issue_rob, issue_rs1_v, prev, 10 + got);
                end
                got++;
            end
            prev = issue_start;
        end
        checks++;
        if (got !== 8 || count !== 4'd0) begin
            errs++;
            $display("FAIL full_drain issued=%0d cnt=%0d exp 8/0", got, count);
        end
        tick(); tick();
    endtask

    task automatic test_head_block();
        logic early;
        int got;
        early = 1'b0;
        push(5'd20, 6'd11, 1'b0, 32'h0, 6'd0, 1'b1, 32'h0);
        push(5'd21, 6'd12, 1'b1, 32'h2121, 6'd0, 1'b1, 32'h0);
        tick(); early |= issue_start;
        tick(); early |= issue_start;
        tick(); early |= issue_start;
        checks++;
        if (early !== 1'b0) begin
            errs++; $display("FAIL head_block got=%b exp=0", early);
        end
        cdb_valid = 1'b1; cdb_phys_rd = 6'd11; cdb_data = 32'h77;
        tick();
        cdb_valid = 1'b0;
        got = 0;
        for (int c = 0; c < 10 && got < 2; c++) begin
            tick();
            if (issue_start) begin
                checks++;
                if (got == 0 && (issue_rob !== 5'd20 || issue_rs1_v !== 32'h77)) begin
                    errs++;
                    $display("FAIL head_first rob=%0d rs1=%h exp 20/77",
                             issue_rob, issue_rs1_v);
                end
                if (got == 1 && (issue_rob !== 5'd21 || issue_rs1_v !== 32'h2121)) begin
                    errs++;
                    $display("FAIL head_second rob=%0d rs1=%h exp 21/2121",
                             issue_rob, issue_rs1_v);
                end
                got++;
            end
        end
        checks++;
        if (got !== 2) begin
            errs++; $display("FAIL head_timeout issued=%0d exp=2", got);
        end
        tick(); tick();
    endtask

    task automatic test_flush();
        logic early;
        early = 1'b0;
        mem_in_use = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push(5'(24 + i), 6'(20 + i), 1'b1, 32'hF0 + 32'(i),
                 6'd0, 1'b1, 32'h0);
        end
        checks++;
        if (count !== 4'd4) begin
            errs++; $display("FAIL flush_pre cnt=%0d exp=4", count);
        end
        disp(5'd30, 6'd30, 1'b1, 32'h30, 6'd0, 1'b1, 32'h0);
        flush = 1'b1;
        mem_in_use = 1'b0;
        tick();
        flush = 1'b0;
        dispatch_valid = 1'b0;
        checks++;
        if (count !== 4'd0 || issue_start !== 1'b0
            || dispatch_ready !== 1'b1) begin
            errs++;
            $display("FAIL flush_clear cnt=%0d start=%b ready=%b exp 0/0/1",
                     count, issue_start, dispatch_ready);
        end
        tick(); early |= issue_start;
        tick(); early |= issue_start;
        tick(); early |= issue_start;
        checks++;
        if (early !== 1'b0) begin
            errs++; $display("FAIL flush_ghost got=%b exp=0", early);
        end
        push(5'd6, 6'd8, 1'b1, 32'h66, 6'd0, 1'b1, 32'h0);
        tick();
        checks++;
        if (issue_start !== 1'b1 || issue_rob !== 5'd6
            || issue_rs1_v !== 32'h66) begin
            errs++;
            $display("FAIL flush_after start=%b rob=%0d rs1=%h exp 1/6/66",
                     issue_start, issue_rob, issue_rs1_v);
        end
        tick(); tick();
    endtask

    task automatic test_async_reset();
        push(5'd9, 6'd13, 1'b1, 32'h99, 6'd0, 1'b1, 32'h0);
        push(5'd10, 6'd14, 1'b1, 32'hAA, 6'd0, 1'b1, 32'h0);
        checks++;
        if (issue_start !== 1'b1 || count !== 4'd1) begin
            errs++;
            $display("FAIL arst_pre start=%b cnt=%0d exp 1/1",
                     issue_start, count);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (issue_start !== 1'b0 || count !== 4'd0 || issue_rob !== 5'd0) begin
            errs++;
            $display("FAIL arst_now start=%b cnt=%0d rob=%0d exp 0/0/0",
                     issue_start, count, issue_rob);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wakeup();
        test_same_cycle_wake();
        test_disp_issue_same();
        test_full();
        test_head_block();
        test_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
